// File: rtl/ex3_to_bcd_seq.sv
// ex3_to_bcd_seq: sequential Excess-3 to BCD decoder, one digit per clock on a valid/ready handshake.
module ex3_to_bcd_seq #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_data,
  output logic [NDIGITS-1:0]     err_mask
);
  localparam int CW = $clog2(NDIGITS + 1);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t               r_state, w_next;
  logic [4*NDIGITS-1:0] r_shift, r_data;
  logic [NDIGITS-1:0]   r_err;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           w_nib, w_bcd;
  logic                 w_bad, w_last;
  assign w_nib     = r_shift[3:0];
  assign w_bad     = (w_nib < 4'd3) || (w_nib > 4'd12);
  assign w_bcd     = w_bad ? 4'hF : w_nib - 4'd3;
  assign w_last    = r_cnt == CW'(NDIGITS - 1);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == HOLD;
  assign out_data  = r_data;
  assign err_mask  = r_err;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = in_valid ? CONV : IDLE;
      CONV:    w_next = w_last ? HOLD : CONV;
      HOLD:    w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_shift <= in_data;
        r_data  <= '0;
        r_err   <= '0;
        r_cnt   <= '0;
      end else if (r_state == CONV) begin
        r_data[4*r_cnt +: 4] <= w_bcd;
        r_err[r_cnt]         <= w_bad;
        r_shift              <= r_shift >> 4;
        r_cnt                <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ex3_to_bcd_seq.sv
// tb_ex3_to_bcd_seq: directed-vector bench for the Excess-3 to BCD decoder (NDIGITS=4).
module tb_ex3_to_bcd_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [15:0] in_data = '0, out_data;
  logic [3:0]  err_mask;
  int          n_cmp = 0, n_err = 0;

  ex3_to_bcd_seq #(.NDIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  // lat counts edges from the accepting edge up to the one after which out_valid is seen
  task automatic send_word(input logic [15:0] d, output int lat);
    lat = 99;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(negedge clk);
    in_data = d;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic release_word();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || err_mask !== 4'h0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h err_mask=%b, want 1 0 0000 0000",
               in_ready, out_valid, out_data, err_mask);
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_basic();
    int lat;
    send_word(16'h3456, lat);
    n_cmp++;
    if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", lat); end
    n_cmp++;
    if (out_data !== 16'h0123 || err_mask !== 4'b0000 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_data: out_data=%h err_mask=%b in_ready=%b, want 0123 0000 0", out_data, err_mask, in_ready);
    end
    release_word();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0123) begin
      n_err++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b out_data=%h, want 0 1 0123", out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_valid_codes();
    int lat;
    logic [15:0] din [2] = '{16'hCCCC, 16'h3333};
    logic [15:0] dexp[2] = '{16'h9999, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      send_word(din[i], lat);
      n_cmp++;
      if (lat !== 5 || out_data !== dexp[i] || err_mask !== 4'b0000) begin
        n_err++;
        $display("FAIL valid_codes[%0d]: lat=%0d out_data=%h err_mask=%b, want 5 %h 0000", i, lat, out_data, err_mask, dexp[i]);
      end
      release_word();
    end
  endtask

  task automatic test_invalid_codes();
    int lat;
    logic [15:0] din [2] = '{16'h3F45, 16'h0D1E};
    logic [15:0] dexp[2] = '{16'h0F12, 16'hFFFF};
    logic [3:0]  mexp[2] = '{4'b0100, 4'b1111};
    for (int i = 0; i < 2; i++) begin
      send_word(din[i], lat);
      n_cmp++;
      if (out_data !== dexp[i] || err_mask !== mexp[i]) begin
        n_err++;
        $display("FAIL invalid_codes[%0d]: out_data=%h err_mask=%b, want %h %b", i, out_data, err_mask, dexp[i], mexp[i]);
      end
      release_word();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_word(16'h789A, lat);
    @(negedge clk);
    in_data = 16'h3333;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h4567 || err_mask !== 4'b0000) begin
        n_err++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b out_data=%h err_mask=%b, want 1 0 4567 0000",
                 i, out_valid, in_ready, out_data, err_mask);
      end
    end
    in_valid = 0;
    release_word();
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_data !== 16'h4567) begin
      n_err++;
      $display("FAIL backpressure_after: in_ready=%b out_data=%h, want 1 4567", in_ready, out_data);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    in_data = 16'hCCCC;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || err_mask !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b out_data=%h err_mask=%b, want 1 0 0000 0000",
               in_ready, out_valid, out_data, err_mask);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    send_word(16'h4567, lat);
    n_cmp++;
    if (lat !== 5 || out_data !== 16'h1234 || err_mask !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_after: lat=%0d out_data=%h err_mask=%b, want 5 1234 0000", lat, out_data, err_mask);
    end
    release_word();
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [3] = '{16'h3456, 16'hCCCC, 16'h3F45};
    logic [15:0] dexp[3] = '{16'h0123, 16'h9999, 16'h0F12};
    logic [3:0]  mexp[3] = '{4'b0000, 4'b0000, 4'b0100};
    int acc[3] = '{0, 0, 0};
    int idx = 0, oi = 0;
    out_ready = 1;
    for (int c = 0; c < 60 && oi < 3; c++) begin
      @(negedge clk);
      in_data  = idx < 3 ? din[idx] : 16'h0;
      in_valid = idx < 3;
      if (in_ready && in_valid) begin
        acc[idx] = c;
        idx++;
      end
      if (out_valid) begin
        n_cmp++;
        if (out_data !== dexp[oi] || err_mask !== mexp[oi]) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: out_data=%h err_mask=%b, want %h %b", oi, out_data, err_mask, dexp[oi], mexp[oi]);
        end
        oi++;
      end
    end
    in_valid = 0;
    out_ready = 0;
    n_cmp++;
    if (oi !== 3) begin n_err++; $display("FAIL b2b_count: got %0d results want 3", oi); end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (acc[i] - acc[i-1] !== 6) begin
        n_err++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles want 6", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_codes();
    test_invalid_codes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
